// File: rtl/alu_seq_ctrl.sv
// Sequencing controller in front of the 16-bit ALU: accepts one operation, holds the
// ALU inputs for an opcode-dependent latency, captures result and flags, returns it.
module alu_seq_ctrl #(
    parameter int BASE_LAT   = 1,
    parameter int RED_LAT    = 2,
    parameter int PADDSB_LAT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_opcode,
    input  logic [15:0] req_rs,
    input  logic [15:0] req_rt,
    input  logic [15:0] req_imm,
    output logic [3:0]  alu_opcode,
    output logic [15:0] alu_rs,
    output logic [15:0] alu_rt,
    output logic [15:0] alu_imm,
    input  logic [15:0] alu_rd,
    input  logic        alu_z,
    input  logic        alu_n,
    input  logic        alu_v,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_rd,
    output logic        flag_z,
    output logic        flag_n,
    output logic        flag_v,
    output logic        halted
);

    localparam int B_LAT = (BASE_LAT   < 1) ? 1 : BASE_LAT;
    localparam int R_LAT = (RED_LAT    < 1) ? 1 : RED_LAT;
    localparam int P_LAT = (PADDSB_LAT < 1) ? 1 : PADDSB_LAT;
    localparam int MAX_AB = (B_LAT > R_LAT) ? B_LAT : R_LAT;
    localparam int MAX_LAT = (MAX_AB > P_LAT) ? MAX_AB : P_LAT;
    localparam int CW = $clog2(MAX_LAT) + 1;

    localparam logic [3:0] OP_ADD    = 4'b0000;
    localparam logic [3:0] OP_SUB    = 4'b0001;
    localparam logic [3:0] OP_XOR    = 4'b0010;
    localparam logic [3:0] OP_RED    = 4'b0011;
    localparam logic [3:0] OP_SLL    = 4'b0100;
    localparam logic [3:0] OP_SRA    = 4'b0101;
    localparam logic [3:0] OP_ROR    = 4'b0110;
    localparam logic [3:0] OP_PADDSB = 4'b0111;
    localparam logic [3:0] OP_HLT    = 4'b1111;

    typedef enum logic [1:0] {IDLE, EXEC, RESP, HALT} state_t;

    state_t        state;
    logic [CW-1:0] cnt;

    // Counter preload is latency minus one so the capture lands L edges after accept.
    function automatic logic [CW-1:0] lat_m1(input logic [3:0] op);
        case (op)
            OP_RED:    lat_m1 = CW'(R_LAT - 1);
            OP_PADDSB: lat_m1 = CW'(P_LAT - 1);
            default:   lat_m1 = CW'(B_LAT - 1);
        endcase
    endfunction

    // req_ready is a pure decode of the state register, so it is high during reset too.
    assign req_ready = (state == IDLE);

    // NOTE: all state updates use non-blocking assignments so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            alu_opcode <= '0;
            alu_rs     <= '0;
            alu_rt     <= '0;
            alu_imm    <= '0;
            rsp_valid  <= 1'b0;
            rsp_rd     <= '0;
            flag_z     <= 1'b0;
            flag_n     <= 1'b0;
            flag_v     <= 1'b0;
            halted     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        alu_opcode <= req_opcode;
                        alu_rs     <= req_rs;
                        alu_rt     <= req_rt;
                        alu_imm    <= req_imm;
                        cnt        <= lat_m1(req_opcode);
                        if (req_opcode == OP_HLT) begin
                            halted <= 1'b1;
                            state  <= HALT;
                        end else begin
                            state <= EXEC;
                        end
                    end
                end
                EXEC: begin
                    if (cnt == '0) begin
                        rsp_rd    <= alu_rd;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                        case (alu_opcode)
                            OP_ADD, OP_SUB: begin
                                flag_z <= alu_z;
                                flag_n <= alu_n;
                                flag_v <= alu_v;
                            end
                            OP_XOR, OP_SLL, OP_SRA, OP_ROR: flag_z <= alu_z;
                            default: ;
                        endcase
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                HALT: ;  // only reset leaves HALT
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed bench for alu_seq_ctrl: the bench plays the ALU by driving alu_rd/flags
// per vector, then checks latency, alu_* stability, result, flags and handshakes.
module tb_alu_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready;
    logic [3:0]  req_opcode;
    logic [15:0] req_rs, req_rt, req_imm;
    logic [3:0]  alu_opcode;
    logic [15:0] alu_rs, alu_rt, alu_imm, alu_rd;
    logic        alu_z, alu_n, alu_v;
    logic        rsp_valid, rsp_ready;
    logic [15:0] rsp_rd;
    logic        flag_z, flag_n, flag_v, halted;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    alu_seq_ctrl #(.BASE_LAT(1), .RED_LAT(3), .PADDSB_LAT(2)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_opcode(req_opcode),
        .req_rs(req_rs), .req_rt(req_rt), .req_imm(req_imm),
        .alu_opcode(alu_opcode), .alu_rs(alu_rs), .alu_rt(alu_rt), .alu_imm(alu_imm),
        .alu_rd(alu_rd), .alu_z(alu_z), .alu_n(alu_n), .alu_v(alu_v),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rd(rsp_rd),
        .flag_z(flag_z), .flag_n(flag_n), .flag_v(flag_v), .halted(halted)
    );

    typedef struct {
        logic [3:0]  op;
        logic [15:0] rs, rt, imm;
        logic [15:0] ard;
        logic [2:0]  azvn;   // {z,n,v} driven by the bench-as-ALU
        int          lat;
        logic [2:0]  eflags; // expected {flag_z,flag_n,flag_v} after capture
        bit          early;  // rsp_ready held high before rsp_valid
        int          hold;   // cycles of rsp_ready low while response pending
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string name);
        check(name, {alu_opcode, alu_rs, alu_rt, alu_imm, rsp_valid, rsp_rd,
                     flag_z, flag_n, flag_v, halted, req_ready}, {73'd0, 1'b1});
    endtask

    task automatic do_op(input vec_t v, input string tag);
        int lat;
        alu_rd = v.ard;
        {alu_z, alu_n, alu_v} = v.azvn;
        req_opcode = v.op; req_rs = v.rs; req_rt = v.rt; req_imm = v.imm;
        req_valid = 1'b1;
        check({tag, " ready_idle"}, req_ready, 1'b1);
        tick();
        check({tag, " alu_regs"}, {alu_opcode, alu_rs, alu_rt, alu_imm}, {v.op, v.rs, v.rt, v.imm});
        check({tag, " ready_busy"}, req_ready, 1'b0);
        lat = 0;
        rsp_ready = v.early;
        while (!rsp_valid && lat < 10) begin
            req_opcode = 4'($urandom); req_rs = 16'($urandom);
            req_rt = 16'($urandom); req_imm = 16'($urandom);
            tick();
            lat++;
            check({tag, " alu_hold"}, {alu_opcode, alu_rs, alu_rt, alu_imm}, {v.op, v.rs, v.rt, v.imm});
        end
        check({tag, " latency"}, 128'(lat), 128'(v.lat));
        check({tag, " rsp_rd"}, rsp_rd, v.ard);
        check({tag, " flags"}, {flag_z, flag_n, flag_v}, v.eflags);
        rsp_ready = 1'b0;
        for (int i = 0; i < v.hold; i++) begin
            tick();
            check({tag, " bp_hold"}, {rsp_valid, rsp_rd, req_ready, flag_z, flag_n, flag_v},
                  {1'b1, v.ard, 1'b0, v.eflags});
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check({tag, " rsp_done"}, {rsp_valid, req_ready}, 2'b01);
    endtask

    initial begin
        //           op       rs       rt       imm      ard      zn v    lat  eflags early hold
        vecs[0]  = '{4'b0000, 16'h7FFF, 16'h0001, 16'h0000, 16'h8000, 3'b011, 1, 3'b011, 0, 0};
        vecs[1]  = '{4'b0010, 16'h1234, 16'h1234, 16'h0000, 16'h0000, 3'b100, 1, 3'b111, 0, 0};
        vecs[2]  = '{4'b1010, 16'h0000, 16'h0000, 16'h00AB, 16'h00AB, 3'b001, 1, 3'b111, 0, 0};
        vecs[3]  = '{4'b0011, 16'hAAAA, 16'h5555, 16'h0000, 16'h0009, 3'b010, 3, 3'b111, 0, 0};
        vecs[4]  = '{4'b0001, 16'h0003, 16'h0005, 16'h0000, 16'hFFFE, 3'b010, 1, 3'b010, 0, 0};
        vecs[5]  = '{4'b0100, 16'h8001, 16'h0000, 16'h0001, 16'h0002, 3'b001, 1, 3'b010, 0, 0};
        vecs[6]  = '{4'b0111, 16'h7070, 16'h1010, 16'h0000, 16'h7F7F, 3'b111, 2, 3'b010, 1, 0};
        vecs[7]  = '{4'b0110, 16'h0000, 16'h0000, 16'h0003, 16'h0000, 3'b100, 1, 3'b110, 0, 0};
        vecs[8]  = '{4'b0101, 16'h8000, 16'h0000, 16'h0004, 16'hF800, 3'b011, 1, 3'b010, 0, 0};
        vecs[9]  = '{4'b1110, 16'h0000, 16'h0000, 16'h0000, 16'h1236, 3'b111, 1, 3'b010, 0, 0};
        vecs[10] = '{4'b0000, 16'h0001, 16'h0001, 16'h0000, 16'h0002, 3'b000, 1, 3'b000, 0, 0};
        vecs[11] = '{4'b1000, 16'h0100, 16'h0000, 16'h0004, 16'h4321, 3'b100, 1, 3'b000, 0, 0};
        vecs[12] = '{4'b0001, 16'h0005, 16'h0005, 16'h0000, 16'h0000, 3'b100, 1, 3'b100, 0, 5};

        rst = 1'b1;
        req_valid = 1'b0; req_opcode = '0; req_rs = '0; req_rt = '0; req_imm = '0;
        alu_rd = '0; alu_z = 1'b0; alu_n = 1'b0; alu_v = 1'b0; rsp_ready = 1'b0;
        #1;
        check_reset_outputs("reset_state");
        tick(); tick();
        rst = 1'b0;
        tick();
        check_reset_outputs("post_reset_idle");

        foreach (vecs[i]) do_op(vecs[i], $sformatf("vec%0d", i));

        // HLT: halts, stays unresponsive, keeps flags and alu_* until reset.
        req_opcode = 4'b1111; req_rs = 16'h00FF; req_rt = 16'h0F0F; req_imm = 16'h0001;
        req_valid = 1'b1;
        tick();
        check("hlt_halted", {halted, req_ready, alu_opcode}, {1'b1, 1'b0, 4'b1111});
        for (int i = 0; i < 20; i++) begin
            tick();
            check("hlt_stuck", {halted, req_ready, rsp_valid, flag_z, flag_n, flag_v, alu_opcode, alu_rs},
                  {3'b100, 3'b100, 4'b1111, 16'h00FF});
        end
        req_valid = 1'b0;
        rst = 1'b1;
        #1;
        check_reset_outputs("hlt_reset");
        tick();
        rst = 1'b0;
        tick();

        // Set some flags, then abort a PADDSB in its second EXEC cycle.
        do_op('{4'b0000, 16'hFFFF, 16'hFFFF, 16'h0000, 16'hFFFE, 3'b010, 1, 3'b010, 0, 0}, "pre_abort");
        alu_rd = 16'hBEEF; {alu_z, alu_n, alu_v} = 3'b111;
        req_opcode = 4'b0111; req_rs = 16'h1111; req_rt = 16'h2222; req_imm = '0;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        tick();
        check("abort_mid_exec", {rsp_valid, req_ready, alu_opcode}, {2'b00, 4'b0111});
        rst = 1'b1;
        #1;
        check_reset_outputs("abort_reset");
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("abort_no_rsp", {rsp_valid, req_ready, rsp_rd}, {2'b01, 16'h0000});
        end
        do_op('{4'b0000, 16'h0002, 16'h0003, 16'h0000, 16'h0005, 3'b000, 1, 3'b000, 0, 0}, "post_abort");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach the end");
        $fatal(1);
    end

endmodule
